btn_debounce: RTL

Counter-based switch/button debouncer that consumes an already-synchronized one-bit input and produces a clean level plus single-cycle edge pulses. It sits directly downstream of the input synchronizer flip-flop stage and upstream of counters, clock-divider enables and LED logic that must see exactly one event per physical press.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_timer.sv | 40 ++++
 rtl/btn_debounce.sv | 133 +++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the button debouncer: 2-bit FSM encodings and
// qualification lengths for board and simulation builds.
package debounce_pkg;

   localparam logic [1:0] S_LOW       = 2'd0;
   localparam logic [1:0] S_WAIT_HIGH = 2'd1;
   localparam logic [1:0] S_HIGH      = 2'd2;
   localparam logic [1:0] S_WAIT_LOW  = 2'd3;

   // 10 ms at 100 MHz for board builds; short window for simulation.
   localparam int unsigned STABLE_CYCLES_BOARD = 1_000_000;
   localparam int unsigned STABLE_CYCLES_SIM   = 4;

endpackage

// File: rtl/debounce_timer.sv
// Qualification counter for the debouncer: clears or increments on request,
// flags done when the count reaches STABLE_CYCLES-1 (never wraps in use).
module debounce_timer #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             incr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             done_o
);

   localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(STABLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (incr_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign done_o = (cnt_q == DONE_CNT);

endmodule

// File: rtl/btn_debounce.sv
// Counter-based debouncer for a pre-synchronized switch level. Edge pulses
// are generated only when DEBOUNCE_EDGE_EN is defined; otherwise tied to 0.
module btn_debounce
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_BOARD,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic db_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   logic [1:0]       state_q, state_d;
   logic             db_q, db_d;
   logic             tmr_clear, tmr_incr, tmr_done;
   logic [CNT_W-1:0] cnt;
`ifdef DEBOUNCE_EDGE_EN
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
`endif

   debounce_timer #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear_i (tmr_clear),
      .incr_i  (tmr_incr),
      .cnt_o   (cnt),
      .done_o  (tmr_done)
   );

   // Stable states hold the counter at 0, so a single increment on leaving
   // them starts the candidate run at cnt=1.
   always_comb begin
      state_d   = state_q;
      db_d      = db_q;
      tmr_clear = 1'b0;
      tmr_incr  = 1'b0;
`ifdef DEBOUNCE_EDGE_EN
      rise_d    = 1'b0;
      fall_d    = 1'b0;
`endif
      case (state_q)
         S_LOW: begin
            if (din) begin
               state_d  = S_WAIT_HIGH;
               tmr_incr = 1'b1;
            end else begin
               tmr_clear = 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (!din) begin
               state_d   = S_LOW;
               tmr_clear = 1'b1;
            end else if (tmr_done) begin
               state_d   = S_HIGH;
               db_d      = 1'b1;
               tmr_clear = 1'b1;
`ifdef DEBOUNCE_EDGE_EN
               rise_d    = 1'b1;
`endif
            end else begin
               tmr_incr = 1'b1;
            end
         end
         S_HIGH: begin
            if (!din) begin
               state_d  = S_WAIT_LOW;
               tmr_incr = 1'b1;
            end else begin
               tmr_clear = 1'b1;
            end
         end
         S_WAIT_LOW: begin
            if (din) begin
               state_d   = S_HIGH;
               tmr_clear = 1'b1;
            end else if (tmr_done) begin
               state_d   = S_LOW;
               db_d      = 1'b0;
               tmr_clear = 1'b1;
`ifdef DEBOUNCE_EDGE_EN
               fall_d    = 1'b1;
`endif
            end else begin
               tmr_incr = 1'b1;
            end
         end
         default: begin
            state_d   = S_LOW;
            tmr_clear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOW;
         db_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         db_q    <= db_d;
      end
   end

`ifdef DEBOUNCE_EDGE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
`else
   assign rise_pulse = 1'b0;
   assign fall_pulse = 1'b0;
`endif

   assign db_out = db_q;

endmodule
